uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Receives a byte stream over a UART line and writes it sequentially into the byte-wide data memory, starting at address 0.
- Sits directly upstream of the data memory, driving its write enable, address and data-in ports.
- Used to preload image or program data from a host before processing starts.
- Reports load progress, completion, and line errors.

Parameters:
- N, 16, memory address/data bus width; matches the data memory. The memory stores the low N/2 bits.
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Must be >= 4.
- LOAD_BYTES, 65536, number of bytes to write before load completes. Range 1..2^N.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART line; idles high; 8 data bits, LSB first, 1 stop bit, no parity by default.
- load_start  input  1  single-cycle pulse that arms a new load.
- mem_write_en  output  1  one-cycle write strobe to the data memory.
- mem_addr  output  N  write address.
- mem_datain  output  N  write data = {(N/2)'b0, byte}.
- busy  output  1  high while in LOADING.
- load_done  output  1  high in DONE.
- byte_count  output  N+1  bytes written in the current load.
- framing_err  output  1  sticky; set on a bad stop bit; cleared by reset or load_start.

Behaviour:
- Reset: mem_write_en, mem_addr, mem_datain, busy, load_done, byte_count and framing_err all go to 0. Synchronizer flops go to 1. Both FSMs go to IDLE.
- rx passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- RX FSM states:
  - R_IDLE: waits for synchronized rx = 0, then loads the bit timer and moves to R_START.
  - R_START: after CLKS_PER_BIT/2 cycles (integer division), samples rx. If 0, move to R_DATA with bit index 0. If 1, treat as a glitch and return to R_IDLE with no side effects.
  - R_DATA: samples every CLKS_PER_BIT cycles and shifts into the byte LSB first. After bit 7, move to R_STOP.
  - R_STOP: samples after CLKS_PER_BIT cycles. If 1, raise internal byte_valid for exactly one cycle. If 0, set framing_err and drop the byte. Either way, return to R_IDLE.
- Loader FSM states:
  - IDLE: byte_valid is ignored. load_start clears byte_count and framing_err and moves to LOADING.
  - LOADING: on byte_valid, in the next cycle, mem_write_en=1, mem_addr=byte_count[N-1:0], mem_datain={0,byte}; byte_count increments in the same cycle. When the incremented count equals LOAD_BYTES, move to DONE.
  - DONE: load_done=1. byte_valid is ignored and mem_write_en stays 0. load_start restarts exactly as it does from IDLE.
- Address and data hold their last values when mem_write_en=0. mem_write_en is never high for more than one consecutive cycle.
- load_start while LOADING restarts the load: count returns to 0 and errors clear.
- Simultaneous byte_valid and load_start: load_start wins and the byte is dropped.
- End-to-end latency: the write strobe occurs 2 (sync) + 1 (byte_valid) + 1 (register) cycles after the stop-bit sample point.
- byte_count is N+1 bits wide so that LOAD_BYTES=2^N is reachable. The address wraps naturally only at 2^N, which coincides with DONE.
- reset asserted mid-frame aborts the frame immediately. The partial byte is never written.

Optional Feature:
- Macro: UART_PARITY_CHECK_EN.
- When defined:
  - The RX FSM adds an R_PARITY state between R_DATA and R_STOP, expecting even parity.
  - Adds output parity_err (1 bit, sticky, cleared by reset or load_start).
  - On a parity mismatch, parity_err is set and the byte is dropped, even if the stop bit is good.
- When undefined: 10-bit frames, no parity_err port.

Test Plan:
- Single byte: reset, load_start, send 0xA5 at CLKS_PER_BIT=8. Expect one mem_write_en pulse with mem_addr=0x0000 and mem_datain=0x00A5; byte_count=1; busy=1.
- Full load: LOAD_BYTES=4, send 0x11,0x22,0x33,0x44. Expect writes at addresses 0..3, then load_done=1 and busy=0. A fifth byte 0x55 produces no write.
- Framing error: send 0x3C with stop bit=0. Expect no write, framing_err=1, byte_count unchanged. The next good byte 0x7E writes at the same address.
- Glitch: rx low for 3 cycles (less than CLKS_PER_BIT/2=4). Expect no write and the RX FSM back in R_IDLE.
- Reset mid-frame: assert reset after 4 data bits. Expect all outputs 0 and no write. A following full frame of 0x81 after load_start writes at addr 0.
- With UART_PARITY_CHECK_EN: 0x03 with parity 1 gives parity_err=1 and no write. 0x03 with parity 0 writes 0x0003.

Source files
------------

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Purpose  : UART (8N1) receiver that writes received bytes sequentially into
//            a byte-wide data memory from address 0. Optional even-parity
//            checking is enabled by defining UART_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader #(
    parameter int          N            = 16,
    parameter int          CLKS_PER_BIT = 434,
    parameter int unsigned LOAD_BYTES   = 65536
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    input  logic         load_start,
    output logic         mem_write_en,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_datain,
    output logic         busy,
    output logic         load_done,
    output logic [N:0]   byte_count,
`ifdef UART_PARITY_CHECK_EN
    output logic         parity_err,
`endif
    output logic         framing_err
);

    localparam int              c_TW      = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_FULL_M1 = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_HALF_M1 = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N:0]      c_LOAD    = (N+1)'(LOAD_BYTES);

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_START  = 3'd1,
        R_DATA   = 3'd2,
        R_PARITY = 3'd3,
        R_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        L_IDLE    = 2'd0,
        L_LOADING = 2'd1,
        L_DONE    = 2'd2
    } ld_state_t;

    // Receiver state
    logic            r_rx_meta, r_rx_sync;
    rx_state_t       r_rx_state, w_rx_state_nx;
    logic [c_TW-1:0] r_timer, w_timer_nx;
    logic [2:0]      r_bit_idx, w_bit_idx_nx;
    logic [7:0]      r_shift, w_shift_nx;
    logic            r_byte_valid, w_byte_valid_nx;
    logic            w_fe_set;
    logic            w_tick;
`ifdef UART_PARITY_CHECK_EN
    logic            r_par_bad, w_par_bad_nx;
    logic            w_pe_set;
    logic            r_pe, w_pe_nx;
`endif

    // Loader state
    ld_state_t       r_ld_state, w_ld_state_nx;
    logic            r_we, w_we_nx;
    logic [N-1:0]    r_addr, w_addr_nx;
    logic [N-1:0]    r_data, w_data_nx;
    logic [N:0]      r_count, w_count_nx, w_count_inc;
    logic            r_fe, w_fe_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_state   <= R_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
`ifdef UART_PARITY_CHECK_EN
            r_par_bad    <= 1'b0;
            r_pe         <= 1'b0;
`endif
            r_ld_state   <= L_IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_count      <= '0;
            r_fe         <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_state   <= w_rx_state_nx;
            r_timer      <= w_timer_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_shift      <= w_shift_nx;
            r_byte_valid <= w_byte_valid_nx;
`ifdef UART_PARITY_CHECK_EN
            r_par_bad    <= w_par_bad_nx;
            r_pe         <= w_pe_nx;
`endif
            r_ld_state   <= w_ld_state_nx;
            r_we         <= w_we_nx;
            r_addr       <= w_addr_nx;
            r_data       <= w_data_nx;
            r_count      <= w_count_nx;
            r_fe         <= w_fe_nx;
        end
    end

    assign w_tick = (r_timer == '0);

    always_comb begin
        w_rx_state_nx   = r_rx_state;
        w_timer_nx      = r_timer;
        w_bit_idx_nx    = r_bit_idx;
        w_shift_nx      = r_shift;
        w_byte_valid_nx = 1'b0;
        w_fe_set        = 1'b0;
`ifdef UART_PARITY_CHECK_EN
        w_par_bad_nx    = r_par_bad;
        w_pe_set        = 1'b0;
`endif
        if (r_rx_state != R_IDLE && !w_tick)
            w_timer_nx = r_timer - c_TW'(1);
        case (r_rx_state)
            R_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_state_nx = R_START;
                    w_timer_nx    = c_HALF_M1;
                end
            end
            R_START: begin
                // A start bit that is high at mid-bit is treated as line noise.
                if (w_tick) begin
                    if (!r_rx_sync) begin
                        w_rx_state_nx = R_DATA;
                        w_timer_nx    = c_FULL_M1;
                        w_bit_idx_nx  = '0;
                    end else begin
                        w_rx_state_nx = R_IDLE;
                    end
                end
            end
            R_DATA: begin
                if (w_tick) begin
                    w_shift_nx   = {r_rx_sync, r_shift[7:1]};
                    w_timer_nx   = c_FULL_M1;
                    w_bit_idx_nx = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_CHECK_EN
                        w_rx_state_nx = R_PARITY;
`else
                        w_rx_state_nx = R_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_CHECK_EN
            R_PARITY: begin
                if (w_tick) begin
                    w_par_bad_nx  = r_rx_sync ^ (^r_shift);
                    w_pe_set      = r_rx_sync ^ (^r_shift);
                    w_timer_nx    = c_FULL_M1;
                    w_rx_state_nx = R_STOP;
                end
            end
`endif
            R_STOP: begin
                if (w_tick) begin
                    w_rx_state_nx = R_IDLE;
                    if (r_rx_sync) begin
`ifdef UART_PARITY_CHECK_EN
                        w_byte_valid_nx = !r_par_bad;
`else
                        w_byte_valid_nx = 1'b1;
`endif
                    end else begin
                        w_fe_set = 1'b1;
                    end
                end
            end
            default: w_rx_state_nx = R_IDLE;
        endcase
    end

    assign w_count_inc = r_count + (N+1)'(1);

    // load_start has priority over a byte arriving in the same cycle.
    always_comb begin
        w_ld_state_nx = r_ld_state;
        w_we_nx       = 1'b0;
        w_addr_nx     = r_addr;
        w_data_nx     = r_data;
        w_count_nx    = r_count;
        w_fe_nx       = r_fe | w_fe_set;
`ifdef UART_PARITY_CHECK_EN
        w_pe_nx       = r_pe | w_pe_set;
`endif
        if (load_start) begin
            w_ld_state_nx = L_LOADING;
            w_count_nx    = '0;
            w_fe_nx       = 1'b0;
`ifdef UART_PARITY_CHECK_EN
            w_pe_nx       = 1'b0;
`endif
        end else if (r_ld_state == L_LOADING && r_byte_valid) begin
            w_we_nx    = 1'b1;
            w_addr_nx  = r_count[N-1:0];
            w_data_nx  = N'(r_shift);
            w_count_nx = w_count_inc;
            if (w_count_inc == c_LOAD)
                w_ld_state_nx = L_DONE;
        end
    end

    assign mem_write_en = r_we;
    assign mem_addr     = r_addr;
    assign mem_datain   = r_data;
    assign busy         = (r_ld_state == L_LOADING);
    assign load_done    = (r_ld_state == L_DONE);
    assign byte_count   = r_count;
    assign framing_err  = r_fe;
`ifdef UART_PARITY_CHECK_EN
    assign parity_err   = r_pe;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Purpose  : Self-checking bench for uart_mem_loader (CLKS_PER_BIT=8,
//            LOAD_BYTES=4); also covers UART_PARITY_CHECK_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int c_CPB = 8;
`ifdef UART_PARITY_CHECK_EN
    localparam int c_NB = 11;
`else
    localparam int c_NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset, rx, load_start;
    logic        mem_write_en, busy, load_done, framing_err;
    logic [15:0] mem_addr, mem_datain;
    logic [16:0] byte_count;
`ifdef UART_PARITY_CHECK_EN
    logic        parity_err;
`endif

    uart_mem_loader #(.N(16), .CLKS_PER_BIT(c_CPB), .LOAD_BYTES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .load_start   (load_start),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_datain   (mem_datain),
        .busy         (busy),
        .load_done    (load_done),
        .byte_count   (byte_count),
`ifdef UART_PARITY_CHECK_EN
        .parity_err   (parity_err),
`endif
        .framing_err  (framing_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  b;
        logic        stop;
        logic        wr;
        logic [15:0] addr;
        logic [16:0] cnt;
        logic        fe;
        logic        done;
    } vec_t;

    wr_t  sb[$];
    vec_t tbl[6];
    int   n_vec = 0;
    int   n_bad = 0;
    logic prev_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every clock advance goes through here so write strobes are never missed.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        if (mem_write_en) begin
            chk("we_pulse_width", {31'd0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_datain);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                chk("wr_data", {16'd0, mem_datain}, {16'd0, e.data});
            end
        end
        prev_we = mem_write_en;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
    endtask

    // ls_at: bit-cycle index at which load_start is pulsed (-1 for none).
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par, input int ls_at);
        logic [c_NB-1:0] fr;
        fr        = '1;
        fr[0]     = 1'b0;
        fr[8:1]   = b;
`ifdef UART_PARITY_CHECK_EN
        fr[9]     = (^b) ^ bad_par;
`endif
        fr[c_NB-1] = stop;
        for (int k = 0; k < c_NB; k++) begin
            for (int c = 0; c < c_CPB; c++) begin
                tick();
                if (c == 0) rx = fr[k];
                load_start = ((k * c_CPB + c) == ls_at);
            end
        end
        tick();
        rx = 1'b1;
        load_start = 1'b0;
        ticks(c_CPB);
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [7:0] b);
        wr_t e;
        e.addr = a;
        e.data = {8'h00, b};
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_we"},    {31'd0, mem_write_en}, 32'd0);
        chk({nm, "_addr"},  {16'd0, mem_addr},     32'd0);
        chk({nm, "_data"},  {16'd0, mem_datain},   32'd0);
        chk({nm, "_busy"},  {31'd0, busy},         32'd0);
        chk({nm, "_done"},  {31'd0, load_done},    32'd0);
        chk({nm, "_count"}, {15'd0, byte_count},   32'd0);
        chk({nm, "_fe"},    {31'd0, framing_err},  32'd0);
`ifdef UART_PARITY_CHECK_EN
        chk({nm, "_pe"},    {31'd0, parity_err},   32'd0);
`endif
    endtask

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 16'd0, 17'd1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 16'd0, 17'd1, 1'b1, 1'b0};
        tbl[2] = '{8'h7E, 1'b1, 1'b1, 16'd1, 17'd2, 1'b1, 1'b0};
        tbl[3] = '{8'h22, 1'b1, 1'b1, 16'd2, 17'd3, 1'b1, 1'b0};
        tbl[4] = '{8'h33, 1'b1, 1'b1, 16'd3, 17'd4, 1'b1, 1'b1};
        tbl[5] = '{8'h55, 1'b1, 1'b0, 16'd0, 17'd4, 1'b1, 1'b1};

        reset = 1'b1;
        rx = 1'b1;
        load_start = 1'b0;
        ticks(3);
        chk_zero("reset");
        reset = 1'b0;
        ticks(4);

        // Bytes arriving before any load_start are ignored.
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        chk("idle_count", {15'd0, byte_count}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        pulse_start();
        chk("start_busy", {31'd0, busy}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].wr) expect_write(tbl[i].addr, tbl[i].b);
            send_frame(tbl[i].b, tbl[i].stop, 1'b0, -1);
            chk($sformatf("v%0d_count", i), {15'd0, byte_count}, {15'd0, tbl[i].cnt});
            chk($sformatf("v%0d_fe", i), {31'd0, framing_err}, {31'd0, tbl[i].fe});
            chk($sformatf("v%0d_done", i), {31'd0, load_done}, {31'd0, tbl[i].done});
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, !tbl[i].done});
        end

        // Restart from DONE clears count and error.
        pulse_start();
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_done", {31'd0, load_done}, 32'd0);
        chk("restart_count", {15'd0, byte_count}, 32'd0);
        chk("restart_fe", {31'd0, framing_err}, 32'd0);

        // Short low pulse: no byte, receiver recovers for the next frame.
        tick(); rx = 1'b0;
        ticks(3); rx = 1'b1;
        ticks(20);
        chk("glitch_count", {15'd0, byte_count}, 32'd0);
        expect_write(16'd0, 8'h11);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        chk("post_glitch_count", {15'd0, byte_count}, 32'd1);

        // Restart mid-load.
        pulse_start();
        chk("mid_restart_count", {15'd0, byte_count}, 32'd0);
        chk("mid_restart_busy", {31'd0, busy}, 32'd1);

        // load_start in the same cycle as byte_valid drops the byte.
        send_frame(8'h99, 1'b1, 1'b0, c_NB * c_CPB - 1);
        chk("collide_count", {15'd0, byte_count}, 32'd0);
        chk("collide_busy", {31'd0, busy}, 32'd1);
        expect_write(16'd0, 8'h42);
        send_frame(8'h42, 1'b1, 1'b0, -1);
        chk("after_collide_count", {15'd0, byte_count}, 32'd1);

        // Reset after start bit and four data bits of 0x81.
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < c_CPB; c++) begin
                tick();
                if (c == 0) rx = (k == 0) ? 1'b0 : ((k == 1) ? 1'b1 : 1'b0);
            end
        end
        reset = 1'b1;
        rx = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(c_NB * c_CPB);
        chk_zero("midframe_reset");
        send_frame(8'h81, 1'b1, 1'b0, -1);
        chk("reset_idle_count", {15'd0, byte_count}, 32'd0);
        pulse_start();
        expect_write(16'd0, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        chk("reset_reload_count", {15'd0, byte_count}, 32'd1);

`ifdef UART_PARITY_CHECK_EN
        pulse_start();
        send_frame(8'h03, 1'b1, 1'b1, -1);
        chk("par_bad_pe", {31'd0, parity_err}, 32'd1);
        chk("par_bad_count", {15'd0, byte_count}, 32'd0);
        expect_write(16'd0, 8'h03);
        send_frame(8'h03, 1'b1, 1'b0, -1);
        chk("par_good_count", {15'd0, byte_count}, 32'd1);
`endif

        ticks(10);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
